// File: rtl/fetch_2_pkg.sv
// Shared fetch-path types: fetch_1 request descriptor and the packet pushed to the
// instruction queue.
package fetch_2_pkg;

  typedef struct packed {
    logic        valid;
    logic [31:0] pc;
  } fetch_reg_1_t;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
  } fetch_pkt_t;

endpackage

// File: rtl/fetch_2_if.sv
// Signal bundle between fetch_1/imem/backend (master side) and fetch_2 (slave side).
interface fetch_2_if;

  logic                       branch_mispredict;
  fetch_2_pkg::fetch_reg_1_t  fetch_1_reg;
  logic [31:0]                imem_rdata;
  logic                       imem_resp;
  logic                       iq_full;
  logic                       iq_push;
  fetch_2_pkg::fetch_pkt_t    iq_pkt;
  logic                       imem_stall;

  modport slave (
    input  branch_mispredict, fetch_1_reg, imem_rdata, imem_resp, iq_full,
    output iq_push, iq_pkt, imem_stall
  );

  modport master (
    output branch_mispredict, fetch_1_reg, imem_rdata, imem_resp, iq_full,
    input  iq_push, iq_pkt, imem_stall
  );

endinterface

// File: rtl/fetch_pkt_fifo.sv
// Small circular FIFO of fetch packets; DEPTH must be a power of two, at least 2.
module fetch_pkt_fifo
  import fetch_2_pkg::*;
#(
  parameter int unsigned DEPTH = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  fetch_pkt_t               pkt_in,
  input  logic                     pop,
  input  logic                     flush,
  output fetch_pkt_t               pkt_out,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;

  fetch_pkt_t      mem_q [DEPTH];
  logic [PW-1:0]   head_q, tail_q;
  logic [CW-1:0]   count_q;

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      // Pointers wrap naturally because DEPTH is a power of two.
      if (push) tail_q <= tail_q + 1'b1;
      if (pop)  head_q <= head_q + 1'b1;
      count_q <= count_q + CW'(push) - CW'(pop);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && !flush && push) mem_q[tail_q] <= pkt_in;
  end

  assign pkt_out = mem_q[head_q];
  assign count   = count_q;

  a_no_overflow: assert property (@(posedge clk) disable iff (rst) count_q <= CW'(DEPTH));
  a_no_push_full: assert property (@(posedge clk) disable iff (rst || flush)
                                   !(push && !pop && count_q == CW'(DEPTH)));

endmodule

// File: rtl/fetch_2.sv
// Second fetch stage: pairs imem responses with their PC, bypasses or buffers them into
// the instruction queue, stalls fetch_1 and drops wrong-path responses.
module fetch_2
  import fetch_2_pkg::*;
#(
  parameter int unsigned DEPTH = 2
) (
  input  logic     clk,
  input  logic     rst,
  fetch_2_if.slave bus
);

  localparam int unsigned CW = $clog2(DEPTH) + 1;

  logic [CW-1:0] count;
  fetch_pkt_t    new_pkt, fifo_out;
  logic          accept, bypass, pop, fifo_push;
  logic          waiting, afull, stall;
  logic          stale_q, stale_d, consumed_q, consumed_d;

  assign accept = bus.imem_resp & bus.fetch_1_reg.valid & ~stale_q & ~consumed_q &
                  ~bus.branch_mispredict;
  assign new_pkt = '{pc: bus.fetch_1_reg.pc, inst: bus.imem_rdata};

  assign bypass    = (count == '0) & ~bus.iq_full & accept;
  assign pop       = (count != '0) & ~bus.iq_full & ~bus.branch_mispredict;
  assign fifo_push = accept & ~bypass;

  // afull leaves one slot free for the response that may still be in flight.
  assign waiting = bus.fetch_1_reg.valid & ~consumed_q & ~bus.imem_resp;
  assign afull   = (count >= CW'(DEPTH - 1));
  assign stall   = waiting | afull | stale_q;

  assign bus.iq_push    = bypass | pop;
  assign bus.iq_pkt     = bypass ? new_pkt : (pop ? fifo_out : '0);
  assign bus.imem_stall = stall;

  always_comb begin
    stale_d    = stale_q;
    consumed_d = consumed_q;
    if (bus.branch_mispredict) begin
      // A single stale bit: at most one wrong-path response is ever outstanding.
      stale_d    = (stale_q & ~bus.imem_resp) | waiting;
      consumed_d = 1'b0;
    end else begin
      if (bus.imem_resp) stale_d = 1'b0;
      if (accept && stall) begin
        consumed_d = 1'b1;
      end else if (!stall) begin
        consumed_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      stale_q    <= 1'b0;
      consumed_q <= 1'b0;
    end else begin
      stale_q    <= stale_d;
      consumed_q <= consumed_d;
    end
  end

  fetch_pkt_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push    (fifo_push),
    .pkt_in  (new_pkt),
    .pop     (pop),
    .flush   (bus.branch_mispredict),
    .pkt_out (fifo_out),
    .count   (count)
  );

endmodule

// File: tb/tb_fetch_2.sv
// Bench for fetch_2: directed literal checks, then a randomized fetch_1/imem environment
// checked every cycle against a queue-based reference model.
module tb_fetch_2;
  import fetch_2_pkg::*;

  localparam int unsigned DEPTH = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   total = 0;
  int   bad = 0;

  fetch_2_if bus();

  fetch_2 #(.DEPTH(DEPTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // Environment state: fetch_1 register and a single-outstanding imem.
  bit          f1_v, f1_iss, f1_ans;
  logic [31:0] f1_pc;
  bit          busy, req_cur;
  int          dly;
  logic [31:0] req_pc;
  fetch_pkt_t  q[$];
  int          full_pct;

  function automatic logic [31:0] inst_of(input logic [31:0] pc);
    return {pc[15:0], ~pc[31:16]} ^ 32'h1357_9bdf;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic drive(input bit v, input logic [31:0] pc, input bit r, input logic [31:0] d,
                       input bit f, input bit m);
    bus.fetch_1_reg.valid = v;
    bus.fetch_1_reg.pc    = pc;
    bus.imem_resp         = r;
    bus.imem_rdata        = d;
    bus.iq_full           = f;
    bus.branch_mispredict = m;
  endtask

  task automatic cyc(input bit v, input logic [31:0] pc, input bit r, input logic [31:0] d,
                     input bit f, input bit m);
    @(negedge clk);
    drive(v, pc, r, d, f, m);
    #1;
  endtask

  task automatic expect_out(input string name, input bit push, input bit stall,
                            input logic [63:0] pkt);
    chk({name, ".push"}, 64'(bus.iq_push), 64'(push));
    chk({name, ".stall"}, 64'(bus.imem_stall), 64'(stall));
    if (push) chk({name, ".pkt"}, bus.iq_pkt, pkt);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    drive(1'b0, '0, 1'b0, '0, 1'b0, 1'b0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic env_clear();
    f1_v = 0; f1_iss = 0; f1_ans = 0; f1_pc = 32'h6000_0000;
    busy = 0; req_cur = 0; dly = 0; req_pc = '0;
    q.delete();
  endtask

  initial begin
    bit          r, m, f, resp_imem, rep, acc, e_push, e_stall;
    logic [31:0] d;
    fetch_pkt_t  newp, e_pkt;

    drive(1'b0, '0, 1'b0, '0, 1'b0, 1'b0);
    do_reset();

    // Reset state.
    cyc(0, 32'h0, 0, 32'h0, 0, 0);
    expect_out("reset", 0, 0, '0);
    chk("reset.pkt", bus.iq_pkt, 64'h0);

    // Streaming: same-cycle bypass.
    cyc(1, 32'h6000_0000, 1, 32'h0000_0013, 0, 0);
    expect_out("stream0", 1, 0, 64'h6000_0000_0000_0013);
    cyc(1, 32'h6000_0004, 1, 32'h0010_0093, 0, 0);
    expect_out("stream1", 1, 0, 64'h6000_0004_0010_0093);
    cyc(1, 32'h6000_0008, 1, 32'h0020_0113, 0, 0);
    expect_out("stream2", 1, 0, 64'h6000_0008_0020_0113);
    cyc(0, 32'h0, 0, 32'h0, 0, 0);
    expect_out("stream_idle", 0, 0, '0);

    // Back-pressure and a held request whose response repeats.
    do_reset();
    cyc(1, 32'h6000_0000, 1, 32'hAAAA_0000, 1, 0);
    expect_out("bp0", 0, 0, '0);
    cyc(1, 32'h6000_0004, 0, 32'h0, 1, 0);
    expect_out("bp1", 0, 1, '0);
    cyc(1, 32'h6000_0004, 1, 32'hAAAA_0004, 1, 0);
    expect_out("bp2", 0, 1, '0);
    cyc(1, 32'h6000_0004, 0, 32'h0, 1, 0);
    expect_out("bp3", 0, 1, '0);
    cyc(1, 32'h6000_0004, 1, 32'hAAAA_0004, 1, 0);
    expect_out("held_repeat", 0, 1, '0);
    cyc(1, 32'h6000_0004, 0, 32'h0, 0, 0);
    expect_out("bp_pop0", 1, 1, 64'h6000_0000_AAAA_0000);
    cyc(1, 32'h6000_0004, 0, 32'h0, 0, 0);
    expect_out("bp_pop1", 1, 1, 64'h6000_0004_AAAA_0004);
    cyc(1, 32'h6000_0004, 0, 32'h0, 0, 0);
    expect_out("bp_empty", 0, 0, '0);

    // Stale response after a mispredict.
    cyc(1, 32'h6000_0010, 0, 32'h0, 0, 0);
    expect_out("st_wait", 0, 1, '0);
    cyc(1, 32'h6000_0010, 0, 32'h0, 0, 1);
    expect_out("st_mis", 0, 1, '0);
    cyc(1, 32'h6000_0100, 0, 32'h0, 0, 0);
    expect_out("st_hold", 0, 1, '0);
    cyc(1, 32'h6000_0100, 1, 32'hDEAD_0010, 0, 0);
    expect_out("st_drop", 0, 1, '0);
    cyc(1, 32'h6000_0100, 1, 32'hBBBB_0100, 0, 0);
    expect_out("st_target", 1, 0, 64'h6000_0100_BBBB_0100);

    // Mispredict coinciding with a response while two entries are held.
    cyc(1, 32'h6000_0104, 1, 32'hCCCC_0104, 1, 0);
    expect_out("md0", 0, 0, '0);
    cyc(1, 32'h6000_0108, 0, 32'h0, 1, 0);
    expect_out("md1", 0, 1, '0);
    cyc(1, 32'h6000_0108, 1, 32'hCCCC_0108, 1, 0);
    expect_out("md2", 0, 1, '0);
    cyc(1, 32'h6000_0108, 1, 32'hCCCC_0108, 0, 1);
    expect_out("md_mis", 0, 1, '0);
    cyc(0, 32'h0, 0, 32'h0, 0, 0);
    expect_out("md_flushed", 0, 0, '0);

    // Reset with entries held, then first response is pushed.
    cyc(1, 32'h6000_0200, 1, 32'hEEEE_0200, 1, 0);
    cyc(1, 32'h6000_0204, 1, 32'hEEEE_0204, 1, 0);
    do_reset();
    cyc(0, 32'h0, 0, 32'h0, 0, 0);
    expect_out("rst_mid", 0, 0, '0);
    chk("rst_mid.pkt", bus.iq_pkt, 64'h0);
    cyc(1, 32'h6000_0000, 1, 32'hFFFF_0000, 0, 0);
    expect_out("rst_first", 1, 0, 64'h6000_0000_FFFF_0000);

    // Randomized phase against the queue model.
    do_reset();
    env_clear();
    full_pct = 0;
    for (int cy = 0; cy < 4000; cy++) begin
      if (cy % 1000 == 999) begin
        do_reset();
        env_clear();
        continue;
      end
      if (cy % 200 == 0) begin
        case ($urandom_range(0, 2))
          0:       full_pct = 0;
          1:       full_pct = 30;
          default: full_pct = 85;
        endcase
      end

      @(negedge clk);
      resp_imem = busy && (dly == 0);
      rep = !resp_imem && !busy && f1_v && f1_ans && ($urandom_range(0, 99) < 30);
      r = resp_imem || rep;
      d = resp_imem ? inst_of(req_pc) : inst_of(f1_pc);
      if (resp_imem && !req_cur) d = ~d;
      m = ($urandom_range(0, 99) < 4);
      f = ($urandom_range(0, 99) < full_pct);
      drive(f1_v, f1_pc, r, d, f, m);
      #1;

      // Model: first current-path response is accepted; oldest packet leaves when possible.
      acc     = resp_imem && req_cur && !f1_ans && !m;
      newp    = '{pc: f1_pc, inst: d};
      e_push  = !m && !f && (q.size() > 0 || acc);
      e_pkt   = (q.size() > 0) ? q[0] : newp;
      e_stall = (f1_v && !f1_ans && !r) || (busy && !req_cur) ||
                (q.size() >= int'(DEPTH) - 1);

      chk("rnd.push", 64'(bus.iq_push), 64'(e_push));
      chk("rnd.stall", 64'(bus.imem_stall), 64'(e_stall));
      if (e_push) chk("rnd.pkt", bus.iq_pkt, e_pkt);

      if (m) begin
        q.delete();
      end else begin
        if (acc) q.push_back(newp);
        if (e_push) void'(q.pop_front());
      end

      if (resp_imem) begin
        busy = 0;
        if (req_cur) f1_ans = 1;
      end else if (busy) begin
        dly--;
      end
      if (m) begin
        if (busy) req_cur = 0;
        f1_v = 1; f1_pc = $urandom() & 32'hFFFF_FFFC; f1_iss = 0; f1_ans = 0;
      end else if (!e_stall) begin
        f1_v = ($urandom_range(0, 99) < 85); f1_pc = f1_pc + 32'd4; f1_iss = 0; f1_ans = 0;
      end
      if (f1_v && !f1_iss && !busy) begin
        busy = 1; dly = $urandom_range(0, 2); req_pc = f1_pc; req_cur = 1; f1_iss = 1;
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
